booth_decode_accumulator: RTL

//   Consumer end of the radix-4 Booth encoder interface. Takes the multiplicand plus the
//   4 overlapping 3-bit Booth groups (seq1..seq4) for one multiplier and decodes one group
//   per cycle into {0, +-M, +-2M}. It shifts each partial product by 2*i and accumulates it

---
 rtl/booth_decode_accumulator_pkg.sv | 37 +++
 rtl/booth_decode_accumulator_pp_gen.sv | 35 +++
 rtl/booth_decode_accumulator.sv | 136 +++++++++++++
 3 files changed

// File: rtl/booth_decode_accumulator_pkg.sv
// booth_pkg: shared types and the Booth group decoder used by the
// booth_decode_accumulator block and its partial-product generator.
//   state_t      : control FSM states (idle / run / done)
//   op_t         : decoded radix-4 Booth operation for one 3-bit group
//   GROUP_W      : bits per Booth group
//   booth_decode : maps a 3-bit group {b2,b1,b0} to an op_t
package booth_pkg;

  localparam int GROUP_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_ZERO,
    OP_POS1,
    OP_POS2,
    OP_NEG1,
    OP_NEG2
  } op_t;

  function automatic op_t booth_decode(input logic [GROUP_W-1:0] grp);
    op_t op;
    case (grp)
      3'b001, 3'b010: op = OP_POS1;
      3'b011:         op = OP_POS2;
      3'b100:         op = OP_NEG2;
      3'b101, 3'b110: op = OP_NEG1;
      default:        op = OP_ZERO;  // 000 and 111
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_decode_accumulator_pp_gen.sv
// booth_pp_gen: combinational radix-4 Booth partial-product generator.
// The multiplicand is sign-extended to 2*WIDTH first, so the x2 and the
// negation never lose the sign (keeps -2^(W-1) * -2^(W-1) exact).
// Ports:
//   group_i        in  GROUP_W   Booth group {b2,b1,b0}
//   multiplicand_i in  WIDTH     signed multiplicand M
//   pp_o           out 2*WIDTH   signed partial product {0,+-M,+-2M} (unshifted)
module booth_pp_gen
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [GROUP_W-1:0] group_i,
  input  logic [WIDTH-1:0]   multiplicand_i,
  output logic [2*WIDTH-1:0] pp_o
);

  logic [2*WIDTH-1:0] m_ext;
  logic [2*WIDTH-1:0] m_x2;

  assign m_ext = {{WIDTH{multiplicand_i[WIDTH-1]}}, multiplicand_i};
  assign m_x2  = m_ext << 1;

  always_comb begin
    pp_o = '0;
    case (booth_decode(group_i))
      OP_POS1: pp_o = m_ext;
      OP_POS2: pp_o = m_x2;
      OP_NEG1: pp_o = '0 - m_ext;
      OP_NEG2: pp_o = '0 - m_x2;
      default: pp_o = '0;
    endcase
  end

endmodule

// File: rtl/booth_decode_accumulator.sv
// booth_decode_accumulator: consumes the multiplicand and the radix-4 Booth
// groups of one multiplier, decodes one group per cycle and accumulates the
// shifted partial products into a signed 2*WIDTH product.
// Optional feature macro: BOOTH_EARLY_TERM_EN -- finish as soon as every
// remaining higher group decodes to zero (variable latency, same product).
// Ports:
//   clk          in  1           clock, rising edge
//   rst_n        in  1           synchronous active-low reset
//   start        in  1           request, sampled only in IDLE
//   multiplicand in  WIDTH       signed M, captured on accepted start
//   seq_bus      in  3*NGROUPS   Booth groups, group i = seq_bus[3i+2:3i]
//   busy         out 1           high while groups are being accumulated
//   done         out 1           one-cycle pulse, product valid from here
//   product      out 2*WIDTH     signed M*Q, held until next accepted start
module booth_decode_accumulator
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [WIDTH-1:0]           multiplicand,
  input  logic [GROUP_W*WIDTH/2-1:0] seq_bus,
  output logic                       busy,
  output logic                       done,
  output logic [2*WIDTH-1:0]         product
);

  localparam int NGROUPS = WIDTH / 2;
  localparam int IDX_W   = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
  localparam int SEQ_W   = GROUP_W * NGROUPS;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;

  logic [GROUP_W-1:0] cur_group;
  logic [2*WIDTH-1:0] pp;
  logic [2*WIDTH-1:0] acc_sum;
  logic               last_group;

  assign cur_group = seq_q[GROUP_W*idx_q +: GROUP_W];

  booth_pp_gen #(
    .WIDTH(WIDTH)
  ) u_pp_gen (
    .group_i        (cur_group),
    .multiplicand_i (m_q),
    .pp_o           (pp)
  );

  // Group idx carries weight 4^idx, i.e. a left shift by 2*idx.
  assign acc_sum = acc_q + (pp << {idx_q, 1'b0});

`ifdef BOOTH_EARLY_TERM_EN
  // upper_zero[i] is set when every group above i decodes to zero, so the
  // run can stop right after group i. The top group always terminates.
  logic [NGROUPS-1:0] upper_zero;

  for (genvar gi = 0; gi < NGROUPS; gi++) begin : g_upper_zero
    if (gi == NGROUPS - 1) begin : g_top
      assign upper_zero[gi] = 1'b1;
    end else begin : g_lower
      assign upper_zero[gi] = upper_zero[gi+1] &
          (booth_decode(seq_q[GROUP_W*(gi+1) +: GROUP_W]) == OP_ZERO);
    end
  end

  assign last_group = upper_zero[idx_q];
`else
  assign last_group = (idx_q == IDX_W'(NGROUPS - 1));
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    product_d = product_q;
    m_d       = m_q;
    seq_d     = seq_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          m_d     = multiplicand;
          seq_d   = seq_bus;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d = acc_sum;
        idx_d = idx_q + IDX_W'(1);
        if (last_group) begin
          // Load the product on the way into DONE so it is valid together
          // with the done pulse.
          product_d = acc_sum;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      product_q <= '0;
      m_q       <= '0;
      seq_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      m_q       <= m_d;
      seq_q     <= seq_d;
    end
  end

  assign busy    = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);
  assign product = product_q;

endmodule
